// File: rtl/cla_serial_adder_ctrl_if.sv
// Operand/result handshake bundle for the serial CLA adder.
// master = operand source and result consumer, slave = adder.
interface cla_serial_adder_ctrl_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
  logic             busy;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf, busy
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf, busy
  );
endinterface

// File: rtl/cla_serial_adder_ctrl.sv
// Serial WIDTH-bit add/sub over one 4-bit CLA slice, LS nibble first; result valid NSLICE cycles after accept.
// Result is held in DONE until out_ready; operands are not accepted again until the result is consumed.
module cla_serial_adder_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  cla_serial_adder_ctrl_if.slave bus
);

  localparam int NSLICE = WIDTH / 4;
  localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  generate
    if ((WIDTH % 4) != 0 || WIDTH < 4) begin : g_bad_width
      $error("cla_serial_adder_ctrl: WIDTH must be a multiple of 4 and >= 4");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic [IDXW-1:0]  idx_q, idx_d;

  logic [3:0] nib_a, nib_b, slice_g, slice_p, slice_s;
  logic [4:0] slice_c;
  logic       last_slice;

  // 4-bit carry-lookahead slice on the currently selected nibble
  always_comb begin
    nib_a = '0;
    nib_b = '0;
    for (int i = 0; i < NSLICE; i++) begin
      if (idx_q == IDXW'(i)) begin
        nib_a = a_q[i*4 +: 4];
        nib_b = b_q[i*4 +: 4];
      end
    end
    slice_g    = nib_a & nib_b;
    slice_p    = nib_a ^ nib_b;
    slice_c[0] = carry_q;
    slice_c[1] = slice_g[0] | (slice_p[0] & carry_q);
    slice_c[2] = slice_g[1] | (slice_p[1] & slice_g[0])
               | (slice_p[1] & slice_p[0] & carry_q);
    slice_c[3] = slice_g[2] | (slice_p[2] & slice_g[1])
               | (slice_p[2] & slice_p[1] & slice_g[0])
               | (slice_p[2] & slice_p[1] & slice_p[0] & carry_q);
    slice_c[4] = slice_g[3] | (slice_p[3] & slice_g[2])
               | (slice_p[3] & slice_p[2] & slice_g[1])
               | (slice_p[3] & slice_p[2] & slice_p[1] & slice_g[0])
               | (slice_p[3] & slice_p[2] & slice_p[1] & slice_p[0] & carry_q);
    slice_s    = slice_p ^ slice_c[3:0];
    last_slice = (idx_q == IDXW'(NSLICE - 1));
  end

  always_comb begin
    state_d      = state_q;
    a_d          = a_q;
    b_d          = b_q;
    sum_d        = sum_q;
    carry_d      = carry_q;
    cout_d       = cout_q;
    ovf_d        = ovf_q;
    idx_d        = idx_q;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.busy      = 1'b0;

    case (state_q)
      IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) begin
          a_d     = bus.a;
          b_d     = bus.sub ? ~bus.b : bus.b;
          carry_d = bus.sub | bus.cin;
          sum_d   = '0;
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        bus.busy = 1'b1;
        for (int i = 0; i < NSLICE; i++) begin
          if (idx_q == IDXW'(i)) sum_d[i*4 +: 4] = slice_s;
        end
        carry_d = slice_c[4];
        idx_d   = idx_q + IDXW'(1);
        if (last_slice) begin
          // The last slice writes the top nibble, so slice_s[3] is the new sum MSB
          cout_d  = slice_c[4];
          ovf_d   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (slice_s[3] != a_q[WIDTH-1]);
          state_d = DONE;
        end
      end
      DONE: begin
        bus.busy      = 1'b1;
        bus.out_valid = 1'b1;
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      idx_q   <= idx_d;
    end
  end

  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;
  assign bus.ovf  = ovf_q;

endmodule
